// File: rtl/sipo_collector.sv
// Serial-in/parallel-out collector: rebuilds WIDTH-bit words from a framed serial stream
// and offers them on a valid/ready holding register. Optional parity bit: SIPO_COLLECTOR_PARITY_EN.
module sipo_collector #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ser_in,
  input  logic             ser_valid,
  input  logic             frame_start,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             overflow,
  output logic             sync_err,
  output logic             parity_err,
  input  logic             clr_err
);

  localparam int CW = $clog2(WIDTH + 1);
`ifdef SIPO_COLLECTOR_PARITY_EN
  localparam int FRAME_BITS = WIDTH + 1;
`else
  localparam int FRAME_BITS = WIDTH;
`endif
  localparam logic [CW-1:0] LAST_CNT = CW'(FRAME_BITS - 1);

  typedef enum logic [0:0] {IDLE, COLLECT} state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             ovf_q, ovf_d;
  logic             sync_q, sync_d;

  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] first_word;
  logic [WIDTH-1:0] word;
  logic             word_done;
  logic             sync_set;
  logic             load;

  // Bit-placement: where a new bit enters and where bit 0 of a fresh word sits.
  always_comb begin
    if (MSB_FIRST) begin
      shifted    = {shift_q[WIDTH-2:0], ser_in};
      first_word = {{(WIDTH-1){1'b0}}, ser_in};
    end else begin
      shifted    = {ser_in, shift_q[WIDTH-1:1]};
      first_word = {ser_in, {(WIDTH-1){1'b0}}};
    end
  end

  // With parity, the final serial bit is the parity bit and the data is already in shift_q.
`ifdef SIPO_COLLECTOR_PARITY_EN
  assign word = shift_q;
`else
  assign word = shifted;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shift_d   = shift_q;
    word_done = 1'b0;
    sync_set  = 1'b0;
    if (ser_valid) begin
      if (frame_start) begin
        sync_set = (state_q == COLLECT);
        state_d  = COLLECT;
        cnt_d    = CW'(1);
        shift_d  = first_word;
      end else if (state_q == COLLECT) begin
        if (cnt_q == LAST_CNT) begin
          word_done = 1'b1;
          state_d   = IDLE;
          cnt_d     = '0;
          shift_d   = '0;
        end else begin
          cnt_d   = cnt_q + 1'b1;
          shift_d = shifted;
        end
      end
    end
  end

  always_comb begin
    load    = word_done && (!valid_q || out_ready);
    data_d  = data_q;
    valid_d = valid_q;
    if (load) begin
      data_d  = word;
      valid_d = 1'b1;
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end
    // A set event in the same cycle as clr_err wins.
    ovf_d  = (word_done && !load) || (ovf_q && !clr_err);
    sync_d = sync_set || (sync_q && !clr_err);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
      sync_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
      sync_q  <= sync_d;
    end
  end

`ifdef SIPO_COLLECTOR_PARITY_EN
  logic par_q, par_d;

  always_comb begin
    par_d = par_q;
    if (load) par_d = (^word) ^ ser_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) par_q <= 1'b0;
    else        par_q <= par_d;
  end

  assign parity_err = par_q;
`else
  assign parity_err = 1'b0;
`endif

  assign out_data  = data_q;
  assign out_valid = valid_q;
  assign overflow  = ovf_q;
  assign sync_err  = sync_q;

endmodule

// File: doc/sipo_collector.md
Name: sipo_collector

Overview:
- Serial-in/parallel-out collector sitting directly downstream of the PISO stager chain.
- Consumes the one-bit serial stream the chain shifts out and reassembles WIDTH-bit words.
- Presents each completed word on a valid/ready output handshake with a one-word holding register.
- Detects framing and overflow errors.

Parameters:
- WIDTH, 8, data bits per word (2..32).
- MSB_FIRST, 1: 1 = first received bit lands in out_data[WIDTH-1]; 0 = first bit lands in out_data[0].

Ports:
- clk  input  1  system clock, all state on posedge.
- rst_n  input  1  asynchronous active-low reset.
- ser_in  input  1  serial data bit from the last stager.
- ser_valid  input  1  ser_in is a real bit this cycle (mirrors the chain's shift enable).
- frame_start  input  1  qualifies ser_in as bit 0 of a new word (only meaningful with ser_valid).
- out_data  output  WIDTH  assembled word.
- out_valid  output  1  out_data holds an unconsumed word.
- out_ready  input  1  consumer accepts out_data when out_valid && out_ready.
- overflow  output  1  sticky: a completed word was dropped because the holding register was full.
- sync_err  output  1  sticky: frame_start arrived mid-word.
- parity_err  output  1  parity mismatch on the word in out_data (see Optional Feature).
- clr_err  input  1  synchronous clear of overflow and sync_err.

Behaviour:
- Reset (async assert, sync release):
  - State IDLE, bit counter 0, shift register 0.
  - out_data 0, out_valid 0, overflow 0, sync_err 0, parity_err 0.
- FSM IDLE:
  - Ignores ser_valid without frame_start.
  - ser_valid && frame_start -> capture ser_in as bit 0, counter = 1, go COLLECT.
- FSM COLLECT, per ser_valid cycle:
  - Capture ser_in into the next bit position and increment the counter.
  - Cycles without ser_valid hold all state (no timeout).
- Bit placement:
  - MSB_FIRST=1: shift left, new bit enters LSB; after WIDTH bits, first bit sits in the MSB.
  - MSB_FIRST=0: shift right, new bit enters MSB.
- Word completion (last data bit sampled):
  - Assembled word is offered to the holding register and the FSM returns to IDLE.
  - A frame_start on the next bit is required for the next word (back-to-back words allowed, no gap cycle).
- Holding register load condition: !out_valid, or out_valid && out_ready in the same cycle (simultaneous drain and load is legal, zero bubbles).
- Load result: out_data and parity_err update, and out_valid = 1 on the next cycle. Latency from last bit sampled to out_valid = 1 cycle.
- Load blocked (out_valid && !out_ready): new word is discarded, overflow set, existing out_data retained unchanged.
- Handshake: out_valid && out_ready with no new word -> out_valid 0 next cycle. While out_valid && !out_ready, out_data stays stable.
- frame_start && ser_valid in COLLECT with counter != 0:
  - Partial word is discarded and sync_err is set.
  - The bit is taken as bit 0 of a new word, counter = 1.
- frame_start without ser_valid: ignored.
- clr_err clears both sticky flags next cycle. A set event in the same cycle wins over clr_err.
- Counter width: clog2(WIDTH+1) bits, never wraps past the terminal count.
- Reset mid-word or mid-handshake: everything returns to reset values immediately. A pending word is lost.

Optional Feature:
- Macro: SIPO_COLLECTOR_PARITY_EN.
- When defined:
  - Each word carries one extra trailing even-parity bit after the WIDTH data bits.
  - Completion occurs after bit WIDTH+1.
  - parity_err is loaded with (XOR of data bits XOR parity bit) alongside out_data.
  - A dropped word still sets overflow only.
- When undefined:
  - Words are exactly WIDTH bits.
  - parity_err is tied to 0 and its logic is not compiled.

Test Plan:
- WIDTH=8, MSB_FIRST=1, out_ready=1: bits 1,0,1,0,0,1,0,1 with frame_start on the first bit -> out_data=8'hA5, out_valid high exactly one cycle, one cycle after the 8th bit.
- MSB_FIRST=0, same bit sequence -> out_data=8'hA5 bit-reversed = 8'hA5 reflected (8'hA5 -> 8'hA5 is palindromic, so use 1,1,0,0,0,0,0,0 -> 8'h03).
- out_ready=0, send words 8'h11 then 8'h22 -> out_data holds 8'h11, overflow=1. Then raise out_ready -> 8'h11 consumed, out_valid drops, 8'h22 never appears.
- Word 8'h33 completes in the same cycle the held 8'h44 is accepted -> 8'h33 on out_data next cycle, out_valid stays high, overflow stays 0.
- frame_start after 5 bits, then 8 clean bits forming 8'hC3 -> sync_err=1, out_data=8'hC3. clr_err pulse -> sync_err=0.
- With SIPO_COLLECTOR_PARITY_EN: 8'h07 plus parity bit 1 -> parity_err=0. 8'h07 plus parity bit 0 -> parity_err=1. Assert rst_n low mid-word -> all outputs 0 and the next frame decodes correctly.
